core_sequencer: RTL and testbench

//  Multi-cycle sequencer for the RV32 core: steps one instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/core_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 core; gates decoder outputs into one-cycle strobes.
// Latency: 4 cycles ALU/branch/jump/store, 5 cycles load, plus memory wait cycles.
// Backpressure: stalls in FETCH/MEM until mem_ready; traps on timeout or illegal opcode.
module core_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic             RegWen_dec,
    input  logic             MemRW_dec,
    input  logic             PCsel_dec,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_data,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_take,
    output logic [2:0]       state,
    output logic             trap_illegal,
    output logic             trap_bus,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam int              WC_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    state_t          state_q;
    state_t          state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            op_legal;
    logic            op_is_mem;
    logic            timed_out;
    logic            set_illegal;
    logic            set_bus;
    logic            mem_req_c;
    logic            mem_we_c;
    logic            ir_we_c;
    logic            rf_we_c;
    logic            pc_we_c;
    logic            pc_take_c;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
            5'b01101, 5'b00101, 5'b11011, 5'b11001: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    end

    assign op_is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);

    // mem_ready in the last allowed wait cycle still completes the access
    assign timed_out = (wait_cnt == WC_LAST) && !mem_ready;

    always_comb begin
        state_nxt   = state_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_is_data = 1'b0;
        ir_we_c     = 1'b0;
        rf_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_take_c   = 1'b0;
        set_illegal = 1'b0;
        set_bus     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timed_out) begin
                    set_bus   = 1'b1;
                    state_nxt = S_TRAP;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (!op_legal) begin
                    set_illegal = 1'b1;
                    state_nxt   = S_TRAP;
                end else if (op_is_mem) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c   = 1'b1;
                mem_is_data = 1'b1;
                mem_we_c    = MemRW_dec;
                if (mem_ready) begin
                    // a store retires directly from MEM with a sequential PC
                    if (MemRW_dec) begin
                        pc_we_c   = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (timed_out) begin
                    set_bus   = 1'b1;
                    state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                rf_we_c   = RegWen_dec;
                pc_we_c   = 1'b1;
                pc_take_c = PCsel_dec;
                state_nxt = S_FETCH;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_FETCH;
        endcase
    end

    // the register resets to FETCH, so strobes are masked for the whole reset window
    assign mem_req = mem_req_c & ~rst;
    assign mem_we  = mem_we_c  & ~rst;
    assign ir_we   = ir_we_c   & ~rst;
    assign rf_we   = rf_we_c   & ~rst;
    assign pc_we   = pc_we_c   & ~rst;
    assign pc_take = pc_take_c & ~rst;
    assign state   = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_nxt != state_q) begin
            wait_cnt <= '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready
                     && wait_cnt != WC_LAST) begin
            wait_cnt <= wait_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_illegal <= 1'b0;
            trap_bus     <= 1'b0;
        end else begin
            if (set_illegal) trap_illegal <= 1'b1;
            if (set_bus)     trap_bus     <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (pc_we_c) begin
            retired <= retired + CNT_W'(1);
        end
    end

    a_irwe_pcwe_excl: assert property (@(posedge clk) disable iff (rst) !(ir_we && pc_we));
    a_req_in_mem_states: assert property (@(posedge clk) disable iff (rst)
        mem_req |-> (state_q == S_FETCH || state_q == S_MEM));

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: per-instruction expected cycle traces are
// built from the stage/latency rules and compared every cycle.
module tb_core_sequencer;

    localparam int TMO = 4;
    localparam int CW  = 4;

    localparam logic [4:0] OP_ADD = 5'b01100;
    localparam logic [4:0] OP_LW  = 5'b00000;
    localparam logic [4:0] OP_SW  = 5'b01000;
    localparam logic [4:0] OP_BEQ = 5'b11000;
    localparam logic [4:0] OP_BAD = 5'b11100;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    opcode;
    logic          regwen_dec;
    logic          memrw_dec;
    logic          pcsel_dec;
    logic          mem_ready;
    logic          mem_req;
    logic          mem_we;
    logic          mem_is_data;
    logic          ir_we;
    logic          rf_we;
    logic          pc_we;
    logic          pc_take;
    logic [2:0]    state;
    logic          trap_illegal;
    logic          trap_bus;
    logic [CW-1:0] retired;

    logic [4:0] legal_ops [0:8] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                    5'b01101, 5'b00101, 5'b11011, 5'b11001};

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] exp_ret;
    logic          exp_ti;
    logic          exp_tb;
    logic          trapped;

    core_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .RegWen_dec   (regwen_dec),
        .MemRW_dec    (memrw_dec),
        .PCsel_dec    (pcsel_dec),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_is_data  (mem_is_data),
        .ir_we        (ir_we),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .pc_take      (pc_take),
        .state        (state),
        .trap_illegal (trap_illegal),
        .trap_bus     (trap_bus),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        for (int i = 0; i < 9; i++)
            if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // strobe vector {mem_req, mem_we, mem_is_data, ir_we, rf_we, pc_we, pc_take}
    function automatic logic [6:0] sv(input logic req, we, isd, irw, rfw, pcw, pct);
        return {req, we, isd, irw, rfw, pcw, pct};
    endfunction

    function automatic logic [6:0] obs();
        return {mem_req, mem_we, mem_is_data, ir_we, rf_we, pc_we, pc_take};
    endfunction

    // One clock: drive mem_ready, check everything mid-cycle, advance past the edge.
    task automatic cyc(input logic rdy, input logic [2:0] st, input logic [6:0] s);
        mem_ready = rdy;
        @(negedge clk);
        chk("state",   32'(state),   32'(st));
        chk("strobes", 32'(obs()),   32'(s));
        chk("retired", 32'(retired), 32'(exp_ret));
        chk("traps",   32'({trap_illegal, trap_bus}), 32'({exp_ti, exp_tb}));
        @(posedge clk);
        #1;
        if (s[1]) exp_ret++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = rnd();
        #1;
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_strobes", 32'(obs()),   32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_traps",   32'({trap_illegal, trap_bus}), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_strobes_hold", 32'(obs()), 32'd0);
        rst     = 1'b0;
        exp_ret = '0;
        exp_ti  = 1'b0;
        exp_tb  = 1'b0;
        trapped = 1'b0;
    endtask

    // wf/wm = memory wait cycles before mem_ready in FETCH/MEM; >= TMO means it never answers.
    task automatic run_instr(input logic [4:0] op, input logic rw, input logic mrw,
                             input logic pcs, input int wf, input int wm);
        opcode     = op;
        regwen_dec = rw;
        memrw_dec  = mrw;
        pcsel_dec  = pcs;
        for (int i = 0; i < wf && i < TMO; i++) cyc(1'b0, 3'd0, sv(1, 0, 0, 0, 0, 0, 0));
        if (wf >= TMO) begin
            exp_tb  = 1'b1;
            trapped = 1'b1;
            return;
        end
        cyc(1'b1, 3'd0, sv(1, 0, 0, 1, 0, 0, 0));
        cyc(rnd(), 3'd1, 7'd0);
        cyc(rnd(), 3'd2, 7'd0);
        if (!is_legal(op)) begin
            exp_ti  = 1'b1;
            trapped = 1'b1;
            return;
        end
        if (op == OP_LW || op == OP_SW) begin
            for (int i = 0; i < wm && i < TMO; i++) cyc(1'b0, 3'd3, sv(1, mrw, 1, 0, 0, 0, 0));
            if (wm >= TMO) begin
                exp_tb  = 1'b1;
                trapped = 1'b1;
                return;
            end
            cyc(1'b1, 3'd3, sv(1, mrw, 1, 0, 0, mrw, 0));
            if (mrw) return;
        end
        cyc(rnd(), 3'd4, sv(0, 0, 0, 0, rw, 1, pcs));
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) cyc(rnd(), 3'd5, 7'd0);
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 29) == 0) return TMO + int'($urandom_range(0, 2));
        return int'($urandom_range(0, TMO - 1));
    endfunction

    initial begin
        logic [4:0] op;
        logic       mrw;
        rst = 1'b0; opcode = '0; regwen_dec = 1'b0; memrw_dec = 1'b0;
        pcsel_dec = 1'b0; mem_ready = 1'b0;
        exp_ret = '0; exp_ti = 1'b0; exp_tb = 1'b0; trapped = 1'b0;
        #2;
        do_reset();

        run_instr(OP_ADD, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("add_retired", 32'(retired), 32'd1);
        run_instr(OP_LW,  1'b1, 1'b0, 1'b0, 0, 3);
        run_instr(OP_SW,  1'b0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_BEQ, 1'b0, 1'b0, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 1'b0, 1'b0, 0, 0);

        run_instr(OP_ADD, 1'b1, 1'b0, 1'b0, TMO, 0);
        trap_hold(3);
        do_reset();
        run_instr(OP_ADD, 1'b1, 1'b0, 1'b0, TMO - 1, 0);
        run_instr(OP_LW,  1'b1, 1'b0, 1'b0, 0, TMO);
        trap_hold(2);
        do_reset();

        run_instr(OP_BAD, 1'b1, 1'b0, 1'b0, 0, 0);
        trap_hold(3);
        do_reset();

        run_instr(OP_ADD, 1'b1, 1'b0, 1'b0, 0, 0);
        opcode = OP_LW; regwen_dec = 1'b1; memrw_dec = 1'b0;
        cyc(1'b1, 3'd0, sv(1, 0, 0, 1, 0, 0, 0));
        cyc(1'b0, 3'd1, 7'd0);
        cyc(1'b0, 3'd2, 7'd0);
        cyc(1'b0, 3'd3, sv(1, 0, 1, 0, 0, 0, 0));
        do_reset();

        for (int i = 0; i < 16; i++) run_instr(OP_ADD, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("retired_wrap", 32'(retired), 32'd0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) op = 5'($urandom);
            else                           op = legal_ops[$urandom_range(0, 8)];
            mrw = (op == OP_SW) ? 1'b1 : (op == OP_LW) ? 1'b0 : rnd();
            run_instr(op, rnd(), mrw, rnd(), pick_wait(), pick_wait());
            if (trapped) begin
                trap_hold(int'($urandom_range(1, 3)));
                do_reset();
            end else if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
